// File: rtl/clarke_park_transform.sv
// Clarke/Park transform: converts two sampled phase currents and the rotor
// angle (given as sin/cos) into rotating-frame currents id and iq.
//
// A single signed 20x18 multiplier is time-shared by a small FSM:
//   beta  = sat18((ia + 2*ib) * (1/sqrt3) >>> 16)
//   id    = sat18((alpha*cos + beta*sin) >>> 16)
//   iq    = sat18((beta*cos  - alpha*sin) >>> 16)
// with alpha = ia. Every right shift is a floor; nothing is rounded.
//
// Each multiply is issued together with a small tag that travels down a
// pipeline next to the product. The tag says where the product belongs
// (beta, id accumulator or iq accumulator). That keeps the consuming side
// independent of exactly which state the FSM is in when a product emerges.

module clarke_park_transform #(
   parameter int g_MUL_LAT   = 2,
   parameter int C_INV_SQRT3 = 37837,
   parameter int C_FRAC      = 16
) (
   input  logic               sys_clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic signed [17:0] ia_i,
   input  logic signed [17:0] ib_i,
   input  logic signed [17:0] sin_i,
   input  logic signed [17:0] cos_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               sat_o,
   output logic signed [17:0] id_o,
   output logic signed [17:0] iq_o
);

   // FSM encoding
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LATCH  = 4'd1;
   localparam logic [3:0] S_BETA   = 4'd2;
   localparam logic [3:0] S_W_BETA = 4'd3;
   localparam logic [3:0] S_AC     = 4'd4;
   localparam logic [3:0] S_BS     = 4'd5;
   localparam logic [3:0] S_AS     = 4'd6;
   localparam logic [3:0] S_BC     = 4'd7;
   localparam logic [3:0] S_W_ACC  = 4'd8;
   localparam logic [3:0] S_SAT    = 4'd9;
   localparam logic [3:0] S_DONE   = 4'd10;

   // Product destination tags carried alongside the multiplier pipeline
   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_BETA = 3'd1;
   localparam logic [2:0] T_AC   = 3'd2;
   localparam logic [2:0] T_BS   = 3'd3;
   localparam logic [2:0] T_AS   = 3'd4;
   localparam logic [2:0] T_BC   = 3'd5;

   // Wait counter: W_BETA lasts g_MUL_LAT cycles. W_ACC lasts g_MUL_LAT+2
   // cycles, which covers the drain of the last product plus one settling
   // cycle. Together they give the fixed 2*g_MUL_LAT+10 cycle latency.
   localparam int              CNT_W     = $clog2(g_MUL_LAT + 5);
   localparam logic [CNT_W-1:0] BETA_LAST = CNT_W'(g_MUL_LAT - 1);
   localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(g_MUL_LAT + 1);

   localparam logic signed [17:0] K_INV_SQRT3 = 18'(C_INV_SQRT3);

   // Clip a value that has already been shifted down to the 18-bit signed
   // range. Bit 18 of the result flags that clipping happened.
   function automatic logic [18:0] sat18(input logic signed [39:0] v);
      logic [18:0] r;
      if (v > 40'sd131071) begin
         r = {1'b1, 18'h1FFFF};
      end else if (v < -40'sd131072) begin
         r = {1'b1, 18'h20000};
      end else begin
         r = {1'b0, v[17:0]};
      end
      return r;
   endfunction

   // Sign-extend an 18-bit operand to the 20-bit multiplier A port
   function automatic logic signed [19:0] ext20(input logic signed [17:0] v);
      return {{2{v[17]}}, v};
   endfunction

   logic [3:0]        state;
   logic [CNT_W-1:0]  cnt;

   logic signed [17:0] ia_r;
   logic signed [17:0] ib_r;
   logic signed [17:0] sin_r;
   logic signed [17:0] cos_r;
   logic signed [17:0] alpha;
   logic signed [17:0] beta;

   logic signed [19:0] op_a;
   logic signed [17:0] op_b;
   logic [2:0]         op_tag;

   logic signed [37:0] prod_pipe [g_MUL_LAT];
   logic [2:0]         tag_pipe  [g_MUL_LAT];

   logic signed [39:0] acc_d;
   logic signed [39:0] acc_q;
   logic               sat_flag;
   logic signed [17:0] id_r;
   logic signed [17:0] iq_r;

   logic signed [19:0] n_sum;
   logic signed [37:0] mul_out;
   logic [2:0]         mul_tag;
   logic signed [39:0] prod_ext;
   logic [18:0]        beta_sat;
   logic [18:0]        id_sat;
   logic [18:0]        iq_sat;

   // n = ia + 2*ib. It fits in 20 bits for any 18-bit inputs, so it cannot overflow.
   assign n_sum = ext20(ia_r) + {ib_r[17], ib_r, 1'b0};

   assign mul_out  = prod_pipe[g_MUL_LAT-1];
   assign mul_tag  = tag_pipe[g_MUL_LAT-1];
   assign prod_ext = {{2{mul_out[37]}}, mul_out};

   assign beta_sat = sat18(prod_ext >>> C_FRAC);
   assign id_sat   = sat18(acc_d >>> C_FRAC);
   assign iq_sat   = sat18(acc_q >>> C_FRAC);

   // Fully pipelined multiplier: the product and its tag emerge g_MUL_LAT
   // cycles after the operand registers are loaded
   always_ff @(posedge sys_clk_i) begin
      if (!reset_i) begin
         for (int i = 0; i < g_MUL_LAT; i++) begin
            prod_pipe[i] <= '0;
            tag_pipe[i]  <= T_NONE;
         end
      end else begin
         prod_pipe[0] <= op_a * op_b;
         tag_pipe[0]  <= op_tag;
         for (int i = 1; i < g_MUL_LAT; i++) begin
            prod_pipe[i] <= prod_pipe[i-1];
            tag_pipe[i]  <= tag_pipe[i-1];
         end
      end
   end

   // Sequencer: captures the inputs, issues the five multiplies, consumes
   // the tagged products, saturates and publishes the result
   always_ff @(posedge sys_clk_i) begin
      if (!reset_i) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ia_r     <= '0;
         ib_r     <= '0;
         sin_r    <= '0;
         cos_r    <= '0;
         alpha    <= '0;
         beta     <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_tag   <= T_NONE;
         acc_d    <= '0;
         acc_q    <= '0;
         sat_flag <= 1'b0;
         id_r     <= '0;
         iq_r     <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         sat_o    <= 1'b0;
         id_o     <= '0;
         iq_o     <= '0;
      end else begin
         done_o <= 1'b0;
         op_tag <= T_NONE;

         case (state)
            S_IDLE: begin
               if (start_i) begin
                  ia_r   <= ia_i;
                  ib_r   <= ib_i;
                  sin_r  <= sin_i;
                  cos_r  <= cos_i;
                  busy_o <= 1'b1;
                  state  <= S_LATCH;
               end
            end
            S_LATCH: begin
               alpha    <= ia_r;
               op_a     <= n_sum;
               op_b     <= K_INV_SQRT3;
               op_tag   <= T_BETA;
               acc_d    <= '0;
               acc_q    <= '0;
               sat_flag <= 1'b0;
               state    <= S_BETA;
            end
            S_BETA: begin
               cnt   <= '0;
               state <= S_W_BETA;
            end
            S_W_BETA: begin
               if (cnt == BETA_LAST) begin
                  cnt   <= '0;
                  state <= S_AC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_AC: begin
               op_a   <= ext20(alpha);
               op_b   <= cos_r;
               op_tag <= T_AC;
               state  <= S_BS;
            end
            S_BS: begin
               op_a   <= ext20(beta);
               op_b   <= sin_r;
               op_tag <= T_BS;
               state  <= S_AS;
            end
            S_AS: begin
               op_a   <= ext20(alpha);
               op_b   <= sin_r;
               op_tag <= T_AS;
               state  <= S_BC;
            end
            S_BC: begin
               op_a   <= ext20(beta);
               op_b   <= cos_r;
               op_tag <= T_BC;
               cnt    <= '0;
               state  <= S_W_ACC;
            end
            S_W_ACC: begin
               if (cnt == ACC_LAST) begin
                  cnt   <= '0;
                  state <= S_SAT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SAT: begin
               id_r     <= id_sat[17:0];
               iq_r     <= iq_sat[17:0];
               sat_flag <= sat_flag | id_sat[18] | iq_sat[18];
               state    <= S_DONE;
            end
            S_DONE: begin
               id_o   <= id_r;
               iq_o   <= iq_r;
               sat_o  <= sat_flag;
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase

         // Route emerging products by tag. These never coincide with the
         // accumulator clear in LATCH or the flag update in SAT.
         case (mul_tag)
            T_BETA: begin
               beta     <= beta_sat[17:0];
               sat_flag <= sat_flag | beta_sat[18];
            end
            T_AC:    acc_d <= acc_d + prod_ext;
            T_BS:    acc_d <= acc_d + prod_ext;
            T_AS:    acc_q <= acc_q - prod_ext;
            T_BC:    acc_q <= acc_q + prod_ext;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clarke_park_transform.sv
// Directed testbench for clarke_park_transform with hand-computed vectors.
// It covers reset, basic angles, floor behaviour, saturation, aborting a
// transform with reset, and back-to-back start handshaking.

module tb_clarke_park_transform;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [17:0] ia;
   logic signed [17:0] ib;
   logic signed [17:0] sn;
   logic signed [17:0] cs;
   logic               busy;
   logic               done;
   logic               sat;
   logic signed [17:0] id;
   logic signed [17:0] iq;

   int checks = 0;
   int passes = 0;

   // Free-running clock
   always #5 clk = ~clk;

   clarke_park_transform #(
      .g_MUL_LAT   (2),
      .C_INV_SQRT3 (37837),
      .C_FRAC      (16)
   ) dut (
      .sys_clk_i (clk),
      .reset_i   (rst_n),
      .start_i   (start),
      .ia_i      (ia),
      .ib_i      (ib),
      .sin_i     (sn),
      .cos_i     (cs),
      .busy_o    (busy),
      .done_o    (done),
      .sat_o     (sat),
      .id_o      (id),
      .iq_o      (iq)
   );

   task automatic check_output(input string tag, input int observed, input int expected);
      checks++;
      if (observed == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input int a, input int b, input int s, input int c);
      ia = 18'(a);
      ib = 18'(b);
      sn = 18'(s);
      cs = 18'(c);
   endtask

   task automatic apply_garbage();
      ia = 18'($urandom);
      ib = 18'($urandom);
      sn = 18'($urandom);
      cs = 18'($urandom);
   endtask

   // One full transform: start, scramble inputs while busy, and check the
   // latency, busy, results and flag
   task automatic run_transform(input string name, input int a, input int b,
                                input int s, input int c, input int exp_id,
                                input int exp_iq, input int exp_sat);
      int k;
      int busy_ok;
      apply_stimulus(a, b, s, c);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      apply_garbage();
      k = 0;
      busy_ok = 1;
      while (!done && k < 40) begin
         if (!busy) busy_ok = 0;
         @(posedge clk);
         #1;
         k++;
      end
      check_output({name, ".latency"}, k, 14);
      check_output({name, ".busy_hi"}, busy_ok, 1);
      check_output({name, ".busy_lo"}, int'(busy), 0);
      check_output({name, ".id"}, int'(id), exp_id);
      check_output({name, ".iq"}, int'(iq), exp_iq);
      check_output({name, ".sat"}, int'(sat), exp_sat);
   endtask

   initial begin
      int vec_ia [3];
      int vec_ib [3];
      int vec_s  [3];
      int vec_c  [3];
      int exp_id [3];
      int exp_iq [3];
      int done_at [3];
      int ndone;
      int hold_err;
      int k;
      int stray;

      rst_n = 1'b0;
      start = 1'b0;
      apply_stimulus(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check_output("rst.busy", int'(busy), 0);
      check_output("rst.done", int'(done), 0);
      check_output("rst.sat", int'(sat), 0);
      check_output("rst.id", int'(id), 0);
      check_output("rst.iq", int'(iq), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_transform("theta0", 1000, 0, 0, 65536, 1000, 577, 0);
      run_transform("theta90", 1000, 0, 65536, 0, 577, -1000, 0);
      run_transform("balanced", 1000, -500, 0, 65536, 1000, 0, 0);
      run_transform("negfloor", -1000, 0, 0, 65536, -1000, -578, 0);
      run_transform("satpos", 131071, 131071, 46341, 46341, 131071, 0, 1);
      run_transform("after_sat", 1000, 0, 0, 65536, 1000, 577, 0);
      run_transform("satneg", -131072, -131072, 46341, 46341, -131072, 0, 1);

      // Abort a transform with reset while it is in W_ACC
      apply_stimulus(1000, 0, 0, 65536);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_output("abort.busy", int'(busy), 0);
      check_output("abort.done", int'(done), 0);
      check_output("abort.id", int'(id), 0);
      check_output("abort.iq", int'(iq), 0);
      rst_n = 1'b1;
      stray = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) stray++;
      end
      check_output("abort.no_done", stray, 0);

      // Hold start high for 40 cycles. Only one start per 15 cycles is
      // accepted, and inputs scrambled while busy must not leak in.
      vec_ia = '{1000, 1000, 1000};
      vec_ib = '{0, 0, -500};
      vec_s  = '{0, 65536, 0};
      vec_c  = '{65536, 0, 65536};
      exp_id = '{1000, 577, 1000};
      exp_iq = '{577, -1000, 0};
      done_at = '{-1, -1, -1};
      ndone = 0;
      hold_err = 0;
      for (int c = 0; c < 40; c++) begin
         if (c % 15 == 0) apply_stimulus(vec_ia[c/15], vec_ib[c/15], vec_s[c/15], vec_c[c/15]);
         else apply_garbage();
         start = 1'b1;
         @(posedge clk);
         #1;
         if (done) begin
            if (ndone < 3) begin
               done_at[ndone] = c;
               check_output($sformatf("hs.id%0d", ndone), int'(id), exp_id[ndone]);
               check_output($sformatf("hs.iq%0d", ndone), int'(iq), exp_iq[ndone]);
            end
            ndone++;
         end else if (ndone > 0 && ndone <= 3) begin
            if (int'(id) != exp_id[ndone-1] || int'(iq) != exp_iq[ndone-1]) hold_err++;
         end
      end
      start = 1'b0;
      check_output("hs.count", ndone, 2);
      check_output("hs.done0_at", done_at[0], 14);
      check_output("hs.done1_at", done_at[1], 29);
      check_output("hs.hold", hold_err, 0);
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_output("hs.tail_wait", k, 5);
      check_output("hs.id2", int'(id), exp_id[2]);
      check_output("hs.iq2", int'(iq), exp_iq[2]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/clarke_park_transform.md
Name: clarke_park_transform

Overview:
- Upstream feeder of the FOC current-loop PI stages.
- Converts two sampled phase currents (ia, ib) and the rotor angle (as sin/cos) into the rotating-frame currents id and iq.
- The outputs drive the PI controllers' actual-input ports, and done_o strobes their start.
- Uses one time-shared signed multiplier sequenced by an FSM, to save DSP resources.

Parameters:
- g_MUL_LAT, 2, number of pipeline register stages in the internal multiplier (≥1).
- C_INV_SQRT3, 37837, 1/√3 in Q16.
- C_FRAC, 16, fractional bits of sin/cos and of C_INV_SQRT3.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- start_i  in  1  request a transform; sampled only in IDLE.
- ia_i  in  18  phase-A current, signed.
- ib_i  in  18  phase-B current, signed.
- sin_i  in  18  sin(θ), signed Q2.16 (65536 = 1.0).
- cos_i  in  18  cos(θ), signed Q2.16.
- busy_o  out  1  high from start acceptance until done_o.
- done_o  out  1  one-cycle pulse; id_o/iq_o are valid.
- sat_o  out  1  set if any saturation occurred in the last transform; updated with done_o.
- id_o  out  18  direct-axis current, signed; holds between transforms.
- iq_o  out  18  quadrature-axis current, signed; holds between transforms.

Behaviour:
- Reset (reset_i=0 at a clock edge): state=IDLE; busy_o, done_o, sat_o, id_o, iq_o, accumulator, multiplier pipeline and operand registers all 0. Reset takes effect from any state; an in-flight transform is discarded and no done_o is produced.
- Inputs are sampled once, on the edge that accepts start_i in IDLE. Later changes to inputs are ignored until the next start.
- start_i while busy_o=1 is ignored (not queued).
- Multiplier: signed 20x18 → 38-bit product. It is fully pipelined, and the result appears g_MUL_LAT cycles after operands are registered.
- FSM states: IDLE → LATCH → BETA → W_BETA → AC → BS → AS → BC → W_ACC → SAT → DONE → IDLE.
- LATCH: alpha = ia. Form n = ia + 2·ib as a 20-bit signed value (no overflow possible). Issue n × C_INV_SQRT3.
- BETA/W_BETA: wait for the product. beta = sat18(product >>> 16), arithmetic shift (floor). Set the sat flag if clipped.
- AC, BS, AS, BC: issue one multiply per cycle, back-to-back: alpha·cos, beta·sin, alpha·sin, beta·cos.
- W_ACC: as products emerge:
  - acc_d = alpha·cos + beta·sin
  - acc_q = beta·cos − alpha·sin
  - both accumulators are 40-bit signed.
- SAT: id = sat18(acc_d >>> 16) and iq = sat18(acc_q >>> 16), clipped to [−131072, 131071]. Set the sat flag on any clip.
- DONE: register id_o, iq_o and sat_o, pulse done_o for one cycle, drop busy_o, return to IDLE.
- Latency for g_MUL_LAT=2: done_o is high in the cycle 14 clock edges after the accepting edge. In general the latency is 2·g_MUL_LAT + 10. A new start_i can be accepted on the edge right after done_o (back-to-back operation).
- Wait states hold exactly long enough for the g_MUL_LAT pipeline; a cycle counter sized for g_MUL_LAT+4 sequences the issue and drain.
- Rounding is floor (truncation toward −∞) everywhere; no rounding constant is added.

Test Plan:
- Reset mid-transform: assert reset_i=0 during W_ACC → next cycle IDLE, busy_o=0, id_o=iq_o=0, and no done_o pulse.
- θ=0 (sin=0, cos=65536), ia=1000, ib=0, start → done_o after 14 cycles with id_o=1000, iq_o=577, sat_o=0, busy_o high throughout.
- θ=90° (sin=65536, cos=0), ia=1000, ib=0 → id_o=577, iq_o=−1000.
- Balanced set: ia=1000, ib=−500, θ=0 → beta=0, so id_o=1000, iq_o=0.
- Saturation: ia=ib=131071, sin=cos=46341 → beta clipped to 131071, id_o=131071, iq_o=0, sat_o=1. The following transform with the first scenario's values reports sat_o=0.
- Handshake: pulse start_i every cycle for 40 cycles → exactly one done_o per 15 cycles (accept edge plus 14). Inputs changed while busy do not affect the results, and id_o/iq_o hold between done_o pulses.
